uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line rate in bit/s; BAUD_DIV = CLK_FREQ/BAUD (integer division, 5208 at defaults); BAUD_DIV SHALL be >= 2.
REQ-003 Parameter DEPTH_LOG2, default 2, log2 of FIFO depth (4 entries at default).
REQ-004 clk  input  1  single system clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 tx_data  input  8  byte to transmit, sampled when tx_wr=1.
REQ-007 tx_wr  input  1  write strobe, one byte per cycle high.
REQ-008 tx_full  output  1  FIFO holds DEPTH entries.
REQ-009 tx_ovf  output  1  one-cycle pulse when a write is dropped.
REQ-010 tx_busy  output  1  high while FIFO non-empty or a frame is in progress.
REQ-011 rs232_tx  output  1  serial line, idle high, registered (no combinational path from any input).

Function
REQ-012 Frame SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); no parity.
REQ-013 Every bit, including stop, SHALL last exactly BAUD_DIV clocks; a frame SHALL last 10*BAUD_DIV clocks.
REQ-014 FIFO SHALL accept tx_data on an edge with tx_wr=1 and tx_full=0; occupancy increments at that edge.
REQ-015 Write with tx_full=1 SHALL be dropped (FIFO unchanged, even if a pop occurs that same edge) and tx_ovf SHALL be 1 for the following cycle only.
REQ-016 State machine SHALL have states IDLE, START, DATA, STOP.
REQ-017 IDLE: rs232_tx=1; if FIFO non-empty at an edge, pop head into 8-bit shift register, go START, rs232_tx=0 from that edge.
REQ-018 START: after BAUD_DIV clocks go DATA, rs232_tx = shift[0], bit index = 0.
REQ-019 DATA: each BAUD_DIV clocks shift right and increment bit index; after bit index 7 completes go STOP, rs232_tx=1.
REQ-020 STOP: after BAUD_DIV clocks, if FIFO non-empty pop and go START directly (rs232_tx=0 at that edge, zero idle gap); else go IDLE.
REQ-021 Baud counter SHALL count 0..BAUD_DIV-1, reload to 0 on every state transition, and only run outside IDLE.
REQ-022 Latency: tx_wr sampled at edge k into an empty FIFO with state IDLE SHALL give rs232_tx=0 from edge k+1.
REQ-023 Simultaneous write and pop on a non-full FIFO SHALL both take effect; occupancy unchanged.
REQ-024 FIFO read/write pointers SHALL wrap modulo DEPTH; occupancy counter DEPTH_LOG2+1 bits wide.
REQ-025 tx_busy SHALL equal (state != IDLE) OR (occupancy != 0), registered or combinational from registers.
REQ-026 Bytes SHALL be transmitted in write order; no byte duplicated or lost unless dropped per REQ-015.

Reset
REQ-027 At any edge with rst=1: state=IDLE, rs232_tx=1, FIFO empty, pointers/counters 0, tx_full=0, tx_ovf=0, tx_busy=0.
REQ-028 Reset mid-frame SHALL abort the frame immediately (rs232_tx=1 after that edge) and discard all queued bytes; no resumption after rst falls.

Verification (CLK_FREQ=80, BAUD=10, BAUD_DIV=8, DEPTH_LOG2=2)
REQ-029 Single byte 0xA5 written at edge k -> rs232_tx low edges k+1..k+8, then 1,0,1,0,0,1,0,1 each 8 clocks, stop high 8 clocks, tx_busy=0 at edge k+81.
REQ-030 Write 0x55 then 0x0F back-to-back -> two frames, 160 clocks total, second start bit begins exactly at end of first stop bit.
REQ-031 Six writes on consecutive cycles while idle -> bytes 1-5 sent in order (first popped before FIFO fills), byte 6 dropped, tx_ovf pulses once, tx_full high while 4 entries.
REQ-032 Assert rst for 1 cycle at clock 40 of a frame with 2 bytes queued -> rs232_tx=1 next cycle, tx_busy=0, no further frames.
REQ-033 Write 0x00 and 0xFF -> line low 9 bit times then high for stop; 0xFF gives start low then high 9 bit times; bit-width checker confirms every transition on an 8-clock boundary.
REQ-034 Random traffic (1000 bytes, random tx_wr gaps) with a serial-line model decoding rs232_tx -> decoded stream equals accepted writes, count of tx_ovf pulses equals dropped writes.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO in front of it.
// 8N1 framing, every bit held for BAUD_DIV clocks, back-to-back frames when
// bytes are queued.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | driving the start bit (0)
// DATA  | shifting out data bits, LSB first
// STOP  | driving the stop bit (1), then next byte or IDLE
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_full,
  output logic       tx_ovf,
  output logic       tx_busy,
  output logic       rs232_tx
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int DEPTH    = 1 << DEPTH_LOG2;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]         BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [DEPTH_LOG2:0]   FULL_CNT  = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  state_t                state, state_nxt;
  logic [CW-1:0]         baud_cnt;
  logic [2:0]            bit_idx, bit_idx_nxt;
  logic [7:0]            shift, shift_nxt;
  logic                  tx_nxt;
  logic                  pop, push, baud_done, fifo_empty;

  assign tx_full    = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  // A full FIFO drops the write even if a pop frees a slot on the same edge.
  assign push       = tx_wr && !tx_full;
  assign baud_done  = (baud_cnt == BAUD_LAST);
  assign tx_busy    = (state != IDLE) || !fifo_empty;

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers, occupancy and the overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      tx_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      tx_ovf <= tx_wr && tx_full;
    end
  end

  // Transmitter state, baud timer, shift register and registered line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      rs232_tx <= 1'b1;
    end else begin
      state    <= state_nxt;
      // Every non-IDLE transition happens on baud_done, so wrapping here
      // also reloads the timer at each state change.
      baud_cnt <= (state == IDLE || baud_done) ? '0 : baud_cnt + 1'b1;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
      rs232_tx <= tx_nxt;
    end
  end

  // Next-state, FIFO pop and next line value.
  always_comb begin
    state_nxt   = state;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    tx_nxt      = rs232_tx;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_nxt = mem[rd_ptr];
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (baud_done) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          tx_nxt      = shift[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            shift_nxt   = {1'b0, shift[7:1]};
            bit_idx_nxt = bit_idx + 1'b1;
            tx_nxt      = shift[1];
          end
        end
      end
      STOP: begin
        if (baud_done) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_nxt = mem[rd_ptr];
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at CLK_FREQ=80, BAUD=10 (8 clocks per bit).
// A frame-level model (byte queue plus remaining-clocks-in-frame count)
// predicts line, busy, full and overflow every cycle; a serial decoder
// rebuilds the byte stream from the line for comparison with accepted writes.
module tb_uart_tx_fifo;
  localparam int DEPTH = 4;
  localparam int BD    = 8;
  localparam int FRAME = 10 * BD;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_full, tx_ovf, tx_busy, rs232_tx;

  uart_tx_fifo #(.CLK_FREQ(80), .BAUD(10), .DEPTH_LOG2(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_full  (tx_full),
    .tx_ovf   (tx_ovf),
    .tx_busy  (tx_busy),
    .rs232_tx (rs232_tx)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mq[$];
  logic [7:0] acc[$];
  logic [7:0] dec[$];
  int         frame_left = 0;
  logic [7:0] cur = '0;
  bit         ovf_exp = 0;
  int         drops = 0;
  int         ovf_seen = 0;
  bit         dec_active = 0;
  int         dec_cnt = 0;
  logic [7:0] dec_byte = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_line();
    int pos, b;
    if (frame_left == 0) return 1'b1;
    pos = FRAME - frame_left;
    b   = pos / BD;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  task automatic model_step(input bit wr, input logic [7:0] d, input bit r);
    bit full, push;
    if (r) begin
      mq.delete();
      frame_left = 0;
      ovf_exp    = 0;
      return;
    end
    full    = (mq.size() == DEPTH);
    push    = wr && !full;
    ovf_exp = wr && full;
    if (wr && full) drops++;
    if (frame_left <= 1 && mq.size() > 0) begin
      cur        = mq.pop_front();
      frame_left = FRAME;
    end else if (frame_left > 0) begin
      frame_left--;
    end
    if (push) begin
      mq.push_back(d);
      acc.push_back(d);
    end
  endtask

  task automatic dec_step(input logic line);
    int idx;
    if (!dec_active) begin
      if (line == 1'b0) begin
        dec_active = 1;
        dec_cnt    = 0;
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % BD == BD / 2 && dec_cnt / BD >= 1 && dec_cnt / BD <= 8) begin
        idx = dec_cnt / BD - 1;
        dec_byte[idx] = line;
      end
      if (dec_cnt == 9 * BD + BD / 2) begin
        check("stop_bit", line, 1);
        dec.push_back(dec_byte);
      end
      if (dec_cnt == FRAME - 1) dec_active = 0;
    end
  endtask

  task automatic tick(input bit wr, input logic [7:0] d, input bit r);
    tx_wr   = wr;
    tx_data = d;
    rst     = r;
    model_step(wr, d, r);
    @(negedge clk);
    check("line", rs232_tx, exp_line());
    check("busy", tx_busy, (frame_left != 0 || mq.size() != 0));
    check("full", tx_full, (mq.size() == DEPTH));
    check("ovf",  tx_ovf, ovf_exp);
    if (tx_ovf === 1'b1) ovf_seen++;
    if (r) dec_active = 0;
    else   dec_step(rs232_tx);
  endtask

  task automatic drain();
    int n = 0;
    while ((frame_left != 0 || mq.size() != 0) && n < 1000) begin
      tick(0, 8'h00, 0);
      n++;
    end
    repeat (3) tick(0, 8'h00, 0);
  endtask

  task automatic compare_streams(input string tag);
    int mism = 0;
    int n;
    check({tag, "_count"}, dec.size(), acc.size());
    n = (dec.size() < acc.size()) ? dec.size() : acc.size();
    for (int i = 0; i < n; i++)
      if (dec[i] !== acc[i]) mism++;
    check({tag, "_bytes"}, mism, 0);
    dec.delete();
    acc.delete();
  endtask

  initial begin
    int o0, d0, gap, n;
    tx_wr   = 1'b0;
    tx_data = 8'h00;
    rst     = 1'b1;

    repeat (3) tick(0, 8'h00, 1);
    repeat (2) tick(0, 8'h00, 0);

    tick(1, 8'hA5, 0);
    drain();
    compare_streams("single_a5");

    tick(1, 8'h55, 0);
    tick(1, 8'h0F, 0);
    drain();
    compare_streams("b2b");

    o0 = ovf_seen;
    for (int i = 0; i < 6; i++) tick(1, 8'(8'h31 + i), 0);
    drain();
    compare_streams("six_wr");
    check("six_ovf_pulses", ovf_seen - o0, 1);

    tick(1, 8'h11, 0);
    tick(1, 8'h22, 0);
    tick(1, 8'h33, 0);
    n = 0;
    while (frame_left > FRAME - 40 && n < 200) begin
      tick(0, 8'h00, 0);
      n++;
    end
    tick(0, 8'h00, 1);
    acc.delete();
    dec.delete();
    repeat (200) tick(0, 8'h00, 0);
    compare_streams("after_rst");

    tick(1, 8'h00, 0);
    tick(1, 8'hFF, 0);
    drain();
    compare_streams("zero_ff");

    o0 = ovf_seen;
    d0 = drops;
    for (int i = 0; i < 1000; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 160) : $urandom_range(0, 40);
      repeat (gap) tick(0, 8'($urandom), 0);
      tick(1, 8'($urandom), 0);
    end
    drain();
    compare_streams("random");
    check("random_ovf_vs_drops", ovf_seen - o0, drops - d0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
